mul_queue_core: RTL and testbench

Parametrised bus-slave multiply accelerator with a command queue. It is the next generation of the single-shot operand/start/result core on the Top bus: the CPU/testbench master pushes up to DEPTH operand pairs, starts the engine once, and the core drains them through a shift-add multiplier. Products land in a result FIFO, with an interrupt when the queue empties. It sits behind the bus decoder at a slave address window.

---
 rtl/mul_queue_pkg.sv | 30 +++
 rtl/mul_queue_core_if.sv | 12 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/mul_queue_core.sv | 175 +++++++++++++++++
 tb/tb_mul_queue_core.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mul_queue_pkg.sv
// Shared definitions for the queued shift-add multiply accelerator:
// register offsets, STATUS bit positions and engine state encoding.
package mul_queue_pkg;

  localparam logic [3:0] OFF_OPA     = 4'h0;
  localparam logic [3:0] OFF_OPB     = 4'h1;
  localparam logic [3:0] OFF_CTRL    = 4'h2;
  localparam logic [3:0] OFF_INTR_EN = 4'h3;
  localparam logic [3:0] OFF_INTR    = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h5;
  localparam logic [3:0] OFF_RES_LO  = 4'h6;
  localparam logic [3:0] OFF_RES_HI  = 4'h7;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_JOB_FULL  = 1;
  localparam int STAT_JOB_EMPTY = 2;
  localparam int STAT_RES_FULL  = 3;
  localparam int STAT_RES_EMPTY = 4;
  localparam int STAT_ERR       = 5;
  localparam int STAT_RUN       = 6;
  localparam int STAT_JOB_CNT   = 8;
  localparam int STAT_RES_CNT   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

endpackage

// File: rtl/mul_queue_core_if.sv
// Slave-window bus between the decoder/master and the multiply queue core.
interface mul_queue_core_if;
  logic        S_sel;
  logic        S_wr;
  logic [7:0]  S_addr;
  logic [31:0] S_din;
  logic [31:0] S_dout;
  logic        interrupt;

  modport master (output S_sel, S_wr, S_addr, S_din, input S_dout, interrupt);
  modport slave  (input S_sel, S_wr, S_addr, S_din, output S_dout, interrupt);
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; rdata is the head entry. Pop on empty and
// push on full are ignored, except that a full FIFO accepts a push when popped.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers alone mark valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mul_queue_core.sv
// Bus-slave multiply accelerator: operand pairs queue in a job FIFO, a radix-2
// shift-add engine drains them into a result FIFO and interrupts when done.
module mul_queue_core
  import mul_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  mul_queue_core_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BIT_W = $clog2(WIDTH);

  logic [3:0]       off;
  logic             wr_en, rd_en;
  logic             ctrl_wr, ctrl_clear, ctrl_start;
  logic             fifo_reset;

  logic             job_push, job_pop, job_full, job_empty;
  logic [PW-1:0]    job_rdata;
  logic [CNT_W-1:0] job_count;
  logic [WIDTH-1:0] job_a, job_b;

  logic             res_push, res_pop, res_full, res_empty;
  logic [PW-1:0]    res_rdata;
  logic [CNT_W-1:0] res_count;
  logic [63:0]      prod_ext;

  state_t           state;
  logic             run, err, intr_en, intr_pending, busy;
  logic [WIDTH-1:0] op_a;
  logic [PW-1:0]    mcand, acc;
  logic [WIDTH-1:0] mplier;
  logic [BIT_W-1:0] bit_cnt;
  logic [31:0]      rd_data, dout_q;
  logic             unused_bus;

  assign off        = bus.S_addr[3:0];
  assign wr_en      = bus.S_sel && bus.S_wr;
  assign rd_en      = bus.S_sel && !bus.S_wr;
  assign ctrl_wr    = wr_en && (off == OFF_CTRL);
  assign ctrl_clear = ctrl_wr && bus.S_din[1];
  assign ctrl_start = ctrl_wr && bus.S_din[0] && !bus.S_din[1];
  assign unused_bus = ^{bus.S_addr[7:4], bus.S_din};

  // Clear flushes both queues through their synchronous reset.
  assign fifo_reset = reset || ctrl_clear;

  assign job_push = wr_en && (off == OFF_OPB);
  assign job_pop  = (state == ST_IDLE) && run && !job_empty;
  assign job_a    = job_rdata[PW-1:WIDTH];
  assign job_b    = job_rdata[WIDTH-1:0];
  assign res_push = (state == ST_PUSH) && !res_full;
  assign res_pop  = rd_en && (off == OFF_RES_HI) && !res_empty;
  assign prod_ext = 64'(res_rdata);
  assign busy     = (state != ST_IDLE);

  sync_fifo #(.DATA_W(PW), .DEPTH(DEPTH)) u_job_fifo (
    .clk   (clk),
    .reset (fifo_reset),
    .push  (job_push),
    .pop   (job_pop),
    .wdata ({op_a, bus.S_din[WIDTH-1:0]}),
    .rdata (job_rdata),
    .full  (job_full),
    .empty (job_empty),
    .count (job_count)
  );

  sync_fifo #(.DATA_W(PW), .DEPTH(DEPTH)) u_res_fifo (
    .clk   (clk),
    .reset (fifo_reset),
    .push  (res_push),
    .pop   (res_pop),
    .wdata (acc),
    .rdata (res_rdata),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      run          <= 1'b0;
      err          <= 1'b0;
      intr_en      <= 1'b0;
      intr_pending <= 1'b0;
      op_a         <= '0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      bit_cnt      <= '0;
    end else begin
      if (wr_en && (off == OFF_OPA))     op_a    <= bus.S_din[WIDTH-1:0];
      if (wr_en && (off == OFF_INTR_EN)) intr_en <= bus.S_din[0];
      if (wr_en && (off == OFF_INTR) && bus.S_din[0]) intr_pending <= 1'b0;
      if (job_push && job_full && !job_pop) err <= 1'b1;
      if (ctrl_start && !run) run <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (run) begin
            if (!job_empty) begin
              mcand   <= PW'(job_a);
              mplier  <= job_b;
              acc     <= '0;
              bit_cnt <= '0;
              state   <= ST_MUL;
            end else begin
              // Queue drained: one interrupt per start, then stop.
              intr_pending <= 1'b1;
              run          <= 1'b0;
            end
          end
        end
        ST_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(WIDTH - 1)) state <= ST_PUSH;
        end
        ST_PUSH: begin
          if (!res_full) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Clear overrides everything above, including an in-flight product.
      if (ctrl_clear) begin
        state        <= ST_IDLE;
        run          <= 1'b0;
        err          <= 1'b0;
        intr_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    case (off)
      OFF_INTR_EN: rd_data[0] = intr_en;
      OFF_INTR:    rd_data[0] = intr_pending;
      OFF_STATUS: begin
        rd_data[STAT_BUSY]          = busy;
        rd_data[STAT_JOB_FULL]      = job_full;
        rd_data[STAT_JOB_EMPTY]     = job_empty;
        rd_data[STAT_RES_FULL]      = res_full;
        rd_data[STAT_RES_EMPTY]     = res_empty;
        rd_data[STAT_ERR]           = err;
        rd_data[STAT_RUN]           = run;
        rd_data[STAT_JOB_CNT +: 8]  = 8'(job_count);
        rd_data[STAT_RES_CNT +: 8]  = 8'(res_count);
      end
      OFF_RES_LO:  if (!res_empty) rd_data = prod_ext[31:0];
      OFF_RES_HI:  if (!res_empty) rd_data = prod_ext[63:32];
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      dout_q <= '0;
    else if (rd_en) dout_q <= rd_data;
  end

  assign bus.S_dout    = dout_q;
  assign bus.interrupt = intr_pending && intr_en;

endmodule

// File: tb/tb_mul_queue_core.sv
// Directed bench for mul_queue_core: a 32x4 instance and an 8x2 instance
// share clock and reset; one bus-op per cycle, outputs sampled on negedge.
module tb_mul_queue_core;
  import mul_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel, wr, tgt8;
  logic [7:0]  addr;
  logic [31:0] din;
  int          n_checks = 0;
  int          n_fail   = 0;

  mul_queue_core_if bus32();
  mul_queue_core_if bus8();

  assign bus32.S_sel  = sel && !tgt8;
  assign bus32.S_wr   = wr;
  assign bus32.S_addr = addr;
  assign bus32.S_din  = din;
  assign bus8.S_sel   = sel && tgt8;
  assign bus8.S_wr    = wr;
  assign bus8.S_addr  = addr;
  assign bus8.S_din   = din;

  always #5 clk = ~clk;

  mul_queue_core #(.WIDTH(32), .DEPTH(4)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
  mul_queue_core #(.WIDTH(8),  .DEPTH(2)) u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge: exactly one rising edge each.
  task automatic bus_write(input logic t8, input logic [3:0] off, input logic [31:0] data);
    tgt8 = t8; sel = 1'b1; wr = 1'b1; addr = {4'h3, off}; din = data;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic t8, input logic [3:0] off, output logic [31:0] data);
    tgt8 = t8; sel = 1'b1; wr = 1'b0; addr = {4'h3, off}; din = '0;
    @(negedge clk);
    data = t8 ? bus8.S_dout : bus32.S_dout;
    sel = 1'b0;
  endtask

  task automatic push_job(input logic t8, input logic [31:0] a, input logic [31:0] b);
    bus_write(t8, OFF_OPA, a);
    bus_write(t8, OFF_OPB, b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_intr(input logic t8, input int bound, output int cycles);
    cycles = 0;
    while (cycles < bound) begin
      @(negedge clk);
      cycles++;
      if ((t8 ? bus8.interrupt : bus32.interrupt) === 1'b1) break;
    end
  endtask

  task automatic check_result(input logic t8, input string tag, input logic [63:0] exp);
    logic [31:0] rd;
    bus_read(t8, OFF_RES_LO, rd);
    check({tag, "_lo"}, rd, exp[31:0]);
    bus_read(t8, OFF_RES_HI, rd);
    check({tag, "_hi"}, rd, exp[63:32]);
  endtask

  initial begin
    logic [31:0] rd;
    int          cyc;

    reset = 1'b1; sel = 1'b0; wr = 1'b0; tgt8 = 1'b0; addr = '0; din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("reset_dout", bus32.S_dout, 32'h0);
    check("reset_intr", {31'h0, bus32.interrupt}, 32'h0);
    bus_read(1'b0, OFF_STATUS, rd);
    check("reset_status32", rd, 32'h0000_0014);
    bus_read(1'b1, OFF_STATUS, rd);
    check("reset_status8", rd, 32'h0000_0014);

    // Three jobs, one start, drain latency 3*(32+2)+1
    bus_write(1'b0, OFF_INTR_EN, 32'h1);
    bus_read(1'b0, OFF_INTR_EN, rd);
    check("intr_en_rb", rd, 32'h1);
    push_job(1'b0, 32'd2, 32'd3);
    push_job(1'b0, 32'd12, 32'd1);
    push_job(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus_write(1'b0, OFF_CTRL, 32'h1);
    wait_intr(1'b0, 300, cyc);
    check("drain3_latency", cyc, 32'd103);
    bus_read(1'b0, OFF_STATUS, rd);
    check("drain3_status", rd, 32'h0003_0004);
    check_result(1'b0, "res_2x3", 64'd6);
    check_result(1'b0, "res_12x1", 64'd12);
    check_result(1'b0, "res_max", 64'hFFFF_FFFE_0000_0001);
    bus_read(1'b0, OFF_INTR, rd);
    check("intr_pending", rd, 32'h1);
    bus_write(1'b0, OFF_INTR, 32'h1);
    check("intr_ack", {31'h0, bus32.interrupt}, 32'h0);

    // Overflow: DEPTH+1 pushes, last one dropped and err set
    for (int i = 0; i < 5; i++) push_job(1'b0, 32'(i + 1), 32'(i + 3));
    bus_read(1'b0, OFF_STATUS, rd);
    check("ovf_status", rd, 32'h0000_0432);
    bus_write(1'b0, OFF_CTRL, 32'h1);
    wait_intr(1'b0, 300, cyc);
    check("ovf_latency", cyc, 32'd137);
    check_result(1'b0, "ovf_1x3", 64'd3);
    check_result(1'b0, "ovf_2x4", 64'd8);
    check_result(1'b0, "ovf_3x5", 64'd15);
    check_result(1'b0, "ovf_4x6", 64'd24);
    bus_read(1'b0, OFF_RES_LO, rd);
    check("ovf_extra_absent", rd, 32'h0);
    bus_write(1'b0, OFF_INTR, 32'h1);
    bus_write(1'b0, OFF_CTRL, 32'h2);
    bus_read(1'b0, OFF_STATUS, rd);
    check("ovf_cleared", rd, 32'h0000_0014);

    // Result FIFO full: engine holds in PUSH until one RES_HI pop
    push_job(1'b0, 32'd5, 32'd6);
    push_job(1'b0, 32'd7, 32'd8);
    push_job(1'b0, 32'd9, 32'd10);
    push_job(1'b0, 32'd11, 32'd12);
    bus_write(1'b0, OFF_CTRL, 32'h1);
    push_job(1'b0, 32'h0001_0000, 32'h0001_0000);
    idle(200);
    bus_read(1'b0, OFF_STATUS, rd);
    check("hold_status", rd, 32'h0004_004D);
    check("hold_no_intr", {31'h0, bus32.interrupt}, 32'h0);
    check_result(1'b0, "hold_5x6", 64'd30);
    wait_intr(1'b0, 20, cyc);
    check("hold_release", cyc, 32'd2);
    check_result(1'b0, "hold_7x8", 64'd56);
    check_result(1'b0, "hold_9x10", 64'd90);
    check_result(1'b0, "hold_11x12", 64'd132);
    check_result(1'b0, "hold_big", 64'h0000_0001_0000_0000);
    bus_write(1'b0, OFF_INTR, 32'h1);

    // Clear mid-MUL, clear-beats-start, then start on an empty queue
    push_job(1'b0, 32'd7, 32'd9);
    bus_write(1'b0, OFF_CTRL, 32'h1);
    idle(5);
    bus_write(1'b0, OFF_CTRL, 32'h2);
    bus_read(1'b0, OFF_STATUS, rd);
    check("clr_status", rd, 32'h0000_0014);
    idle(50);
    bus_read(1'b0, OFF_STATUS, rd);
    check("clr_status_late", rd, 32'h0000_0014);
    check("clr_no_intr", {31'h0, bus32.interrupt}, 32'h0);
    bus_write(1'b0, OFF_CTRL, 32'h3);
    bus_read(1'b0, OFF_STATUS, rd);
    check("clr_wins", rd, 32'h0000_0014);
    check("clr_wins_intr", {31'h0, bus32.interrupt}, 32'h0);
    bus_write(1'b0, OFF_CTRL, 32'h1);
    check("empty_start_t0", {31'h0, bus32.interrupt}, 32'h0);
    idle(1);
    check("empty_start_t1", {31'h0, bus32.interrupt}, 32'h1);
    bus_write(1'b0, OFF_INTR, 32'h1);
    bus_read(1'b0, OFF_INTR, rd);
    check("empty_ack", rd, 32'h0);

    // WIDTH=8, DEPTH=2 instance: 0xFF*0xFF, push at start+10, intr at start+11
    bus_write(1'b1, OFF_INTR_EN, 32'h1);
    push_job(1'b1, 32'hFF, 32'hFF);
    bus_read(1'b1, OFF_STATUS, rd);
    check("w8_status", rd, 32'h0000_0110);
    bus_write(1'b1, OFF_CTRL, 32'h1);
    wait_intr(1'b1, 50, cyc);
    check("w8_latency", cyc, 32'd11);
    check_result(1'b1, "w8_ffxff", 64'h0000_0000_0000_FE01);
    check("w8_dut32_quiet", {31'h0, bus32.interrupt}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
